// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor / resolver: branch condition
// codes decoded in E and the 2-bit saturating counter state encodings.
package branch_predict_resolve_pkg;

    // Branch condition codes carried on branch_ctr_E
    localparam logic [4:0] ALU_EQ  = 5'd1;
    localparam logic [4:0] ALU_NEQ = 5'd2;
    localparam logic [4:0] ALU_LEZ = 5'd3;
    localparam logic [4:0] ALU_GTZ = 5'd4;
    localparam logic [4:0] ALU_GEZ = 5'd5;
    localparam logic [4:0] ALU_LTZ = 5'd6;

    // 2-bit counter states: strongly/weakly not-taken, weakly/strongly taken
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

endpackage

// File: rtl/branch_predict_resolve_cond.sv
// Combinational branch condition evaluator: resolves the direction of the
// E-stage branch from the forwarded operands and the condition code.
module branch_cond_eval
    import branch_predict_resolve_pkg::*;
(
    input  logic [4:0]  branch_ctr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        take
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_data == 32'd0);
    assign rs_neg  = rs_data[31];

    // Decode the condition code; unknown codes never take
    always_comb begin
        take = 1'b0;
        case (branch_ctr)
            ALU_EQ:  take = (rs_data == rt_data);
            ALU_NEQ: take = (rs_data != rt_data);
            ALU_LEZ: take = rs_neg | rs_zero;
            ALU_GTZ: take = ~rs_neg & ~rs_zero;
            ALU_GEZ: take = ~rs_neg;
            ALU_LTZ: take = rs_neg;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch predictor (bimodal or gshare PHT of 2-bit counters) with E-stage
// resolution, counter/GHR training, mispredict detection and statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int PHT_DEPTH = 256,
    parameter int GHR_WIDTH = 8,
    parameter int GSHARE    = 1,
    localparam int IDX      = $clog2(PHT_DEPTH)
)(
    input  logic           clk,
    input  logic           resetn,
    input  logic [31:0]    pc_D,
    output logic           pred_take_D,
    output logic [IDX-1:0] pht_idx_D,
    input  logic           branch_E,
    input  logic           stall_E,
    input  logic [4:0]     branch_ctr_E,
    input  logic [31:0]    rs_data_E,
    input  logic [31:0]    rt_data_E,
    input  logic           pred_take_E,
    input  logic [IDX-1:0] pht_idx_E,
    output logic           actual_take_E,
    output logic           mispredict_E,
    output logic [31:0]    br_count,
    output logic [31:0]    miss_count
);

    logic [1:0]           pht [PHT_DEPTH];
    logic [GHR_WIDTH-1:0] ghr;
    logic                 commit;
    logic [1:0]           ctr_next;
    logic                 unused_pc;

    // Word-aligned PC bits above the index do not participate in lookup
    assign unused_pc = ^{pc_D[31:IDX+2], pc_D[1:0]};

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    branch_cond_eval u_cond (
        .branch_ctr (branch_ctr_E),
        .rs_data    (rs_data_E),
        .rt_data    (rt_data_E),
        .take       (actual_take_E)
    );

    assign mispredict_E = branch_E & (actual_take_E != pred_take_E);
    assign commit       = branch_E & ~stall_E & resetn;
    assign ctr_next     = ctr_update(pht[pht_idx_E], actual_take_E);

    // D-stage lookup; a same-cycle commit to the same entry is bypassed,
    // while the GHR contribution is always the pre-commit history
    always_comb begin
        pht_idx_D = pc_D[IDX+1:2];
        if (GSHARE != 0)
            pht_idx_D = pc_D[IDX+1:2] ^ IDX'(ghr);
        if (commit && (pht_idx_E == pht_idx_D))
            pred_take_D = ctr_next[1];
        else
            pred_take_D = pht[pht_idx_D][1];
    end

    // Reset, then train counter/GHR and update statistics on each commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                pht[i] <= WNT;
            ghr        <= '0;
            br_count   <= 32'd0;
            miss_count <= 32'd0;
        end else if (commit) begin
            pht[pht_idx_E] <= ctr_next;
            ghr            <= GHR_WIDTH'({ghr, actual_take_E});
            br_count       <= sat_inc(br_count);
            if (mispredict_E)
                miss_count <= sat_inc(miss_count);
        end
    end

endmodule
